// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: set-2 scan codes,
// direction encodings, decoder state type and key-flag bit positions.
package ps2_pkg;

  // Scan codes (set 2)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_KP0   = 8'h70;
  localparam logic [7:0] SC_UP    = 8'h75;  // extended
  localparam logic [7:0] SC_DOWN  = 8'h72;  // extended
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
  localparam logic [7:0] SC_RIGHT = 8'h74;  // extended
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Direction encodings
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Decoder state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Key-flag bit positions
  localparam int NUM_KEYS = 11;
  localparam int K_W      = 0;
  localparam int K_S      = 1;
  localparam int K_A      = 2;
  localparam int K_D      = 3;
  localparam int K_SPACE  = 4;
  localparam int K_ENTER  = 5;
  localparam int K_KP0    = 6;
  localparam int K_UP     = 7;
  localparam int K_DOWN   = 8;
  localparam int K_LEFT   = 9;
  localparam int K_RIGHT  = 10;

  // One-hot key mask for a code; extended and plain tables never overlap.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = {NUM_KEYS{1'b0}};
    if (ext) begin
      case (code)
        SC_UP:    m[K_UP]    = 1'b1;
        SC_DOWN:  m[K_DOWN]  = 1'b1;
        SC_LEFT:  m[K_LEFT]  = 1'b1;
        SC_RIGHT: m[K_RIGHT] = 1'b1;
        default:  m = {NUM_KEYS{1'b0}};
      endcase
    end else begin
      case (code)
        SC_W:     m[K_W]     = 1'b1;
        SC_S:     m[K_S]     = 1'b1;
        SC_A:     m[K_A]     = 1'b1;
        SC_D:     m[K_D]     = 1'b1;
        SC_SPACE: m[K_SPACE] = 1'b1;
        SC_ENTER: m[K_ENTER] = 1'b1;
        SC_KP0:   m[K_KP0]   = 1'b1;
        default:  m = {NUM_KEYS{1'b0}};
      endcase
    end
    return m;
  endfunction

  // Fixed-priority direction select: up > down > left > right, 00 when idle.
  function automatic logic [1:0] dir_sel(input logic up, input logic down,
                                         input logic left, input logic right);
    logic [1:0] d;
    if (up)         d = DIR_UP;
    else if (down)  d = DIR_DOWN;
    else if (left)  d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    else            d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes ps2_clk/ps2_dat, glitch-filters the
// clock, shifts in 11-bit frames on filtered falling edges and emits one
// byte_vld strobe per good frame. Stale partial frames are dropped after
// TIMEOUT_CYC idle cycles.
// Build option PS2_PARITY_CHECK_EN: when defined, frames with bad odd
// parity are discarded; otherwise the parity bit is ignored.
module ps2_rx_frame #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_vld
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_r;
  logic [1:0]    dat_sync_r;
  logic          clk_s;
  logic          dat_s;
  logic          filt_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic [TW-1:0] idle_cnt_r;
  logic          parity_ok_s;
  logic          frame_ok_s;

  assign clk_s = clk_sync_r[1];
  assign dat_s = dat_sync_r[1];

  // Two-flop synchronizers; lines idle high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_dat};
    end
  end

  // Glitch filter: accept a new clock level after FILT_LEN equal samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= {FW{1'b0}};
    end else if (clk_s != filt_r) begin
      if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_s;
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end else begin
      filt_cnt_r <= {FW{1'b0}};
    end
  end

  // Filtered falling edge, parity and framing qualification
  always_comb begin
    fall_s = filt_r & ~clk_s & (filt_cnt_r == FILT_LAST);
`ifdef PS2_PARITY_CHECK_EN
    parity_ok_s = ^shift_r[9:1];
`else
    // parity bit deliberately ignored in this build
    parity_ok_s = shift_r[9] | ~shift_r[9];
`endif
    frame_ok_s = ~shift_r[0] & dat_s & parity_ok_s;
  end

  // Frame assembly, stop-bit check, byte strobe and idle timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
      idle_cnt_r <= {TW{1'b0}};
      rx_byte    <= 8'd0;
      byte_vld   <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (fall_s) begin
        idle_cnt_r <= {TW{1'b0}};
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
          if (frame_ok_s) begin
            rx_byte  <= shift_r[8:1];
            byte_vld <= 1'b1;
          end else begin
            rx_byte <= rx_byte;
          end
        end else begin
          // LSB-first: after ten shifts start sits at [0], parity at [9]
          shift_r   <= {dat_s, shift_r[9:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end else if (bit_cnt_r != 4'd0) begin
        if (idle_cnt_r == TMO_LAST) begin
          bit_cnt_r  <= 4'd0;
          idle_cnt_r <= {TW{1'b0}};
        end else begin
          idle_cnt_r <= idle_cnt_r + TW'(1);
        end
      end else begin
        idle_cnt_r <= {TW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: make/break/extended FSM, held-key flags,
// per-player move/bubble controls and one-shot menu key pulses.
// Build option PS2_PARITY_CHECK_EN is honoured by ps2_rx_frame.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       player1_moveen,
  output logic       player2_moveen,
  output logic [1:0] player1_move,
  output logic [1:0] player2_move,
  output logic       player1_bubble,
  output logic       player2_bubble,
  output logic       menu_w_press,
  output logic       menu_s_press,
  output logic       menu_enter_press
);

  logic [7:0]          rx_byte_s;
  logic                byte_vld_s;
  dec_state_t          state_r;
  logic [NUM_KEYS-1:0] flags_r;
  logic [NUM_KEYS-1:0] flags_nxt_s;
  logic [NUM_KEYS-1:0] mask_s;
  logic [NUM_KEYS-1:0] fresh_s;
  logic                is_make_s;
  logic                is_brk_s;
  logic                ext_s;
  logic                is_prefix_s;

  ps2_rx_frame #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte_s),
    .byte_vld (byte_vld_s)
  );

  // Classify the incoming byte and compute the next key flags
  always_comb begin
    is_make_s   = 1'b0;
    is_brk_s    = 1'b0;
    ext_s       = 1'b0;
    is_prefix_s = (rx_byte_s == SC_EXT) || (rx_byte_s == SC_BRK);
    case (state_r)
      ST_IDLE: begin
        ext_s     = 1'b0;
        is_make_s = byte_vld_s & ~is_prefix_s;
      end
      ST_EXT: begin
        ext_s     = 1'b1;
        is_make_s = byte_vld_s & ~is_prefix_s;
      end
      ST_BRK: begin
        ext_s    = 1'b0;
        is_brk_s = byte_vld_s;
      end
      ST_EXT_BRK: begin
        ext_s    = 1'b1;
        is_brk_s = byte_vld_s;
      end
      default: begin
        ext_s     = 1'b0;
        is_make_s = 1'b0;
        is_brk_s  = 1'b0;
      end
    endcase
    mask_s = key_mask(ext_s, rx_byte_s);
    if (is_make_s) begin
      flags_nxt_s = flags_r | mask_s;
      fresh_s     = mask_s & ~flags_r;
    end else if (is_brk_s) begin
      flags_nxt_s = flags_r & ~mask_s;
      fresh_s     = {NUM_KEYS{1'b0}};
    end else begin
      flags_nxt_s = flags_r;
      fresh_s     = {NUM_KEYS{1'b0}};
    end
  end

  // Decoder FSM, key flags and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r          <= ST_IDLE;
      flags_r          <= {NUM_KEYS{1'b0}};
      player1_moveen   <= 1'b0;
      player2_moveen   <= 1'b0;
      player1_move     <= 2'b00;
      player2_move     <= 2'b00;
      player1_bubble   <= 1'b0;
      player2_bubble   <= 1'b0;
      menu_w_press     <= 1'b0;
      menu_s_press     <= 1'b0;
      menu_enter_press <= 1'b0;
    end else begin
      if (byte_vld_s) begin
        case (state_r)
          ST_IDLE: begin
            if (rx_byte_s == SC_EXT)      state_r <= ST_EXT;
            else if (rx_byte_s == SC_BRK) state_r <= ST_BRK;
            else                          state_r <= ST_IDLE;
          end
          ST_EXT: begin
            if (rx_byte_s == SC_BRK)      state_r <= ST_EXT_BRK;
            else if (rx_byte_s == SC_EXT) state_r <= ST_EXT;
            else                          state_r <= ST_IDLE;
          end
          ST_BRK:     state_r <= ST_IDLE;
          ST_EXT_BRK: state_r <= ST_IDLE;
          default:    state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
      flags_r          <= flags_nxt_s;
      player1_moveen   <= flags_nxt_s[K_W] | flags_nxt_s[K_S] | flags_nxt_s[K_A] | flags_nxt_s[K_D];
      player2_moveen   <= flags_nxt_s[K_UP] | flags_nxt_s[K_DOWN] | flags_nxt_s[K_LEFT] | flags_nxt_s[K_RIGHT];
      player1_move     <= dir_sel(flags_nxt_s[K_W], flags_nxt_s[K_S], flags_nxt_s[K_A], flags_nxt_s[K_D]);
      player2_move     <= dir_sel(flags_nxt_s[K_UP], flags_nxt_s[K_DOWN], flags_nxt_s[K_LEFT], flags_nxt_s[K_RIGHT]);
      player1_bubble   <= flags_nxt_s[K_SPACE];
      player2_bubble   <= flags_nxt_s[K_KP0];
      menu_w_press     <= fresh_s[K_W];
      menu_s_press     <= fresh_s[K_S];
      menu_enter_press <= fresh_s[K_ENTER];
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// random key events, compared against a key-event level reference model.
module tb_ps2_key_decoder;

  localparam int H   = 6;     // ps2_clk half period in system clocks
  localparam int TMO = 2000;  // shortened frame timeout for simulation

  logic       clk = 1'b0;
  logic       rstn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       player1_moveen;
  logic       player2_moveen;
  logic [1:0] player1_move;
  logic [1:0] player2_move;
  logic       player1_bubble;
  logic       player2_bubble;
  logic       menu_w_press;
  logic       menu_s_press;
  logic       menu_enter_press;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: key table (code, extended) and held state per key
  // order: W S A D Space Enter KP0 Up Down Left Right
  logic [7:0] tbl_code [11] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A,
                                8'h70, 8'h75, 8'h72, 8'h6B, 8'h74};
  bit         tbl_ext  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit         held     [11];

  int w_cnt = 0;
  int s_cnt = 0;
  int e_cnt = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FILT_LEN    (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .ps2_clk          (ps2_clk),
    .ps2_dat          (ps2_dat),
    .player1_moveen   (player1_moveen),
    .player2_moveen   (player2_moveen),
    .player1_move     (player1_move),
    .player2_move     (player2_move),
    .player1_bubble   (player1_bubble),
    .player2_bubble   (player2_bubble),
    .menu_w_press     (menu_w_press),
    .menu_s_press     (menu_s_press),
    .menu_enter_press (menu_enter_press)
  );

  // Count high cycles of each menu pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (menu_w_press === 1'b1)     w_cnt <= w_cnt + 1;
    if (menu_s_press === 1'b1)     s_cnt <= s_cnt + 1;
    if (menu_enter_press === 1'b1) e_cnt <= e_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_dir(input bit up, input bit dn, input bit lf, input bit rt);
    if (up) return 2'd0;
    if (dn) return 2'd1;
    if (lf) return 2'd2;
    if (rt) return 2'd3;
    return 2'd0;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~(^b)) ^ bad_par;
    f[10]   = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_dat = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (2 * H) @(negedge clk);
    ps2_dat = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input int xw, input int xs, input int xe,
                               input int bw, input int bs, input int be);
    check_val({tag, ":p1en"}, {31'd0, player1_moveen}, {31'd0, held[0] | held[1] | held[2] | held[3]});
    check_val({tag, ":p1mv"}, {30'd0, player1_move}, {30'd0, exp_dir(held[0], held[1], held[2], held[3])});
    check_val({tag, ":p2en"}, {31'd0, player2_moveen}, {31'd0, held[7] | held[8] | held[9] | held[10]});
    check_val({tag, ":p2mv"}, {30'd0, player2_move}, {30'd0, exp_dir(held[7], held[8], held[9], held[10])});
    check_val({tag, ":p1bub"}, {31'd0, player1_bubble}, {31'd0, held[4]});
    check_val({tag, ":p2bub"}, {31'd0, player2_bubble}, {31'd0, held[6]});
    check_val({tag, ":wpulse"}, w_cnt - bw, xw);
    check_val({tag, ":spulse"}, s_cnt - bs, xs);
    check_val({tag, ":epulse"}, e_cnt - be, xe);
  endtask

  // One key event: emit [E0] [F0] code, update model, compare outputs
  task automatic key_event(input string tag, input logic [7:0] code, input bit ext,
                           input bit brk, input bit bad_par);
    int bw, bs, be, idx, xw, xs, xe;
    bit apply;
    bw = w_cnt; bs = s_cnt; be = e_cnt;
    if (ext) send_frame(8'hE0, 1'b0, 11);
    if (brk) send_frame(8'hF0, 1'b0, 11);
    send_frame(code, bad_par, 11);
    repeat (20) @(negedge clk);
    idx = -1;
    for (int k = 0; k < 11; k++)
      if (tbl_code[k] == code && tbl_ext[k] == ext) idx = k;
`ifdef PS2_PARITY_CHECK_EN
    apply = !bad_par;
`else
    apply = 1'b1;
`endif
    xw = 0; xs = 0; xe = 0;
    if (apply && idx >= 0) begin
      if (!brk && !held[idx]) begin
        if (idx == 0) xw = 1;
        if (idx == 1) xs = 1;
        if (idx == 5) xe = 1;
      end
      held[idx] = !brk;
    end
    check_outputs(tag, xw, xs, xe, bw, bs, be);
  endtask

  initial begin
    logic [7:0] rc;
    int r, ki;
    for (int k = 0; k < 11; k++) held[k] = 1'b0;
    rstn    = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("reset", 0, 0, 0, w_cnt, s_cnt, e_cnt);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // W make / break
    key_event("w_make", 8'h1D, 1'b0, 1'b0, 1'b0);
    key_event("w_brk",  8'h1D, 1'b0, 1'b1, 1'b0);
    // P2 priority: left then up, release up
    key_event("p2_left", 8'h6B, 1'b1, 1'b0, 1'b0);
    key_event("p2_up",   8'h75, 1'b1, 1'b0, 1'b0);
    key_event("p2_upbrk", 8'h75, 1'b1, 1'b1, 1'b0);
    // repeated E0 prefix stays extended
    send_frame(8'hE0, 1'b0, 11);
    key_event("p2_right_e0e0", 8'h74, 1'b1, 1'b0, 1'b0);
    // Enter typematic
    key_event("ent1", 8'h5A, 1'b0, 1'b0, 1'b0);
    key_event("ent2", 8'h5A, 1'b0, 1'b0, 1'b0);
    key_event("ent3", 8'h5A, 1'b0, 1'b0, 1'b0);
    key_event("ent_brk", 8'h5A, 1'b0, 1'b1, 1'b0);
    key_event("ent4", 8'h5A, 1'b0, 1'b0, 1'b0);
    // bubbles and non-extended 75
    key_event("space", 8'h29, 1'b0, 1'b0, 1'b0);
    key_event("kp0",   8'h70, 1'b0, 1'b0, 1'b0);
    key_event("kp8",   8'h75, 1'b0, 1'b0, 1'b0);
    key_event("ack",   8'hFA, 1'b0, 1'b0, 1'b0);
    // timeout drops a partial frame
    send_frame(8'hF0, 1'b0, 5);
    repeat (TMO + 200) @(negedge clk);
    key_event("tmo_a", 8'h1C, 1'b0, 1'b0, 1'b0);
    // S with bad parity
    key_event("par_s", 8'h1B, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a frame
    send_frame(8'h23, 1'b0, 4);
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 11; k++) held[k] = 1'b0;
    check_outputs("midrst", 0, 0, 0, w_cnt, s_cnt, e_cnt);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    key_event("post_rst_d", 8'h23, 1'b0, 1'b0, 1'b0);

    // random key events
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        ki = $urandom_range(0, 10);
        key_event("rnd_key", tbl_code[ki], tbl_ext[ki], 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        rc = 8'($urandom_range(0, 255));
        if (rc == 8'hE0 || rc == 8'hF0) rc = 8'hAA;
        key_event("rnd_code", rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
